sdram_cache_arbiter: RTL and testbench

//  Shares the single SDRAM controller Avalon-MM slave between the I-cache (line refill, read-only) and
//  D-cache (line refill / write-back). Serialises whole-line transactions of LINE_WORDS words, pipelines

---
 rtl/sdram_arb_pkg.sv | 36 +++
 rtl/sdram_cache_arbiter_arb_rr2.sv | 69 ++++++
 rtl/sdram_cache_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_cache_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : sdram_arb_pkg
// Brief   : Shared types and width helpers for the SDRAM cache arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sdram_arb_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Which cache currently owns the SDRAM port
  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  // Bits needed to index a word inside a line
  function automatic int line_idx_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Bits needed to hold an outstanding count of 0..max_outstanding inclusive
  function automatic int outs_w(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_cache_arbiter_arb_rr2.sv
//------------------------------------------------------------------------------
// Module  : arb_rr2
// Brief   : Two-requester grant selection (I-cache / D-cache).
//           SDRAM_ARB_RR_EN defined  : round-robin, the port not granted last
//                                      wins a tie; pointer starts at I-cache.
//           SDRAM_ARB_RR_EN undefined: fixed priority, D-cache wins ties.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_rr2
  import sdram_arb_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   req_ic_i,
  input  logic   req_dc_i,
  input  logic   take_i,       // grant is consumed this cycle when valid
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

`ifdef SDRAM_ARB_RR_EN
  owner_e prio_q;
  owner_e prio_d;

  // Priority pointer register: remembers which port should win the next tie
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prio_q <= OWN_IC;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Hand priority to the other port whenever a grant is taken
  always_comb begin
    prio_d = prio_q;
    if (take_i && gnt_valid_o) begin
      prio_d = (gnt_owner_o == OWN_IC) ? OWN_DC : OWN_IC;
    end
  end

  // Round-robin selection: pointer only matters when both request
  always_comb begin
    gnt_valid_o = req_ic_i | req_dc_i;
    if (req_ic_i && req_dc_i) begin
      gnt_owner_o = prio_q;
    end else if (req_dc_i) begin
      gnt_owner_o = OWN_DC;
    end else begin
      gnt_owner_o = OWN_IC;
    end
  end
`else
  // Fixed priority keeps no history, so the clock, reset and take strobe are idle
  logic unused_ok;
  assign unused_ok = &{1'b0, clk_i, rst_n_i, take_i};

  // Fixed-priority selection: D-cache wins any tie
  always_comb begin
    gnt_valid_o = req_ic_i | req_dc_i;
    gnt_owner_o = req_dc_i ? OWN_DC : OWN_IC;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/sdram_cache_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sdram_cache_arbiter
// Brief   : Shares one SDRAM controller Avalon-MM slave between the I-cache
//           (line refill) and D-cache (line refill / write-back). Whole-line
//           transactions, pipelined reads up to MAX_OUTSTANDING deep.
//           Optional macro SDRAM_ARB_RR_EN selects round-robin arbitration
//           (default build: fixed priority, D-cache wins ties).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_cache_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W          = 25,
  parameter int DATA_W          = 16,
  parameter int LINE_WORDS      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  // I-cache port
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  // D-cache port
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wnext,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  // Avalon-MM master toward SDRAM controller
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int LINE_IDX_W = line_idx_w(LINE_WORDS);
  localparam int CNT_W      = LINE_IDX_W + 1;
  localparam int OUTS_W     = outs_w(MAX_OUTSTANDING);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LINE_CNT  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [OUTS_W-1:0] OUTS_ONE  = OUTS_W'(1);
  localparam logic [OUTS_W-1:0] OUTS_MAX  = OUTS_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'(LINE_WORDS - 1));

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [OUTS_W-1:0] outs_q, outs_d;

  logic   gnt_valid;
  owner_e gnt_owner;
  logic   rd_accept;
  logic   wr_accept;
  logic   rd_ret;

  arb_rr2 u_arb (
    .clk_i       (clk_clk),
    .rst_n_i     (reset_reset_n),
    .req_ic_i    (ic_req),
    .req_dc_i    (dc_req),
    .take_i      (state_q == IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  // A command counts only when the slave is not stalling it
  assign rd_accept = avm_read  & ~avm_waitrequest;
  assign wr_accept = avm_write & ~avm_waitrequest;

  // Address walks the line from its aligned base; wraps naturally at 2^ADDR_W
  assign avm_address   = base_q + ADDR_W'(issue_cnt_q);
  assign avm_writedata = dc_wdata;
  assign dc_wnext      = wr_accept;

  // Read data is forwarded combinationally; rvalid alone qualifies it
  assign ic_rdata  = avm_readdata;
  assign dc_rdata  = avm_readdata;
  assign ic_rvalid = rd_ret & (owner_q == OWN_IC);
  assign dc_rvalid = rd_ret & (owner_q == OWN_DC);

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: grant in IDLE, leave RD/WR once the full line is done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ((gnt_owner == OWN_DC) && dc_we) ? WR : RD;
        end
      end
      RD: begin
        if (rd_ret && (ret_cnt_q == LAST_WORD)) begin
          state_d = FIN;
        end
      end
      WR: begin
        if (wr_accept && (issue_cnt_q == LAST_WORD)) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: command strobes, return qualifier and done pulses
  always_comb begin
    avm_read  = 1'b0;
    avm_write = 1'b0;
    rd_ret    = 1'b0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    case (state_q)
      RD: begin
        avm_read = (issue_cnt_q < LINE_CNT) && (outs_q < OUTS_MAX);
        rd_ret   = avm_readdatavalid;
      end
      WR: begin
        avm_write = (issue_cnt_q < LINE_CNT);
      end
      FIN: begin
        ic_done = (owner_q == OWN_IC);
        dc_done = (owner_q == OWN_DC);
      end
      default: ;
    endcase
  end

  // Transaction context registers: owner, line base and the three counters
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      owner_q     <= OWN_IC;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      outs_q      <= '0;
    end else begin
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      outs_q      <= outs_d;
    end
  end

  // Context update: latch on grant, then count issues, returns and in-flight reads
  always_comb begin
    owner_d     = owner_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    outs_d      = outs_q;
    if (state_q == IDLE) begin
      if (gnt_valid) begin
        owner_d     = gnt_owner;
        base_d      = ((gnt_owner == OWN_DC) ? dc_addr : ic_addr) & BASE_MASK;
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        outs_d      = '0;
      end
    end else begin
      if (rd_accept || wr_accept) begin
        issue_cnt_d = issue_cnt_q + CNT_ONE;
      end
      if (rd_ret) begin
        ret_cnt_d = ret_cnt_q + CNT_ONE;
      end
      // Issue and return in the same cycle leave the in-flight count unchanged
      case ({rd_accept, rd_ret})
        2'b10:   outs_d = outs_q + OUTS_ONE;
        2'b01:   outs_d = outs_q - OUTS_ONE;
        default: outs_d = outs_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_cache_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_sdram_cache_arbiter
// Brief   : Self-checking bench for sdram_cache_arbiter with an Avalon slave
//           model and a scoreboard of expected commands and read returns.
//           Honours SDRAM_ARB_RR_EN for the tie-break expectations.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sdram_cache_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int LW     = 8;
  localparam int MO     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ic_req = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_rvalid, ic_done;
  logic              dc_req = 1'b0;
  logic              dc_we = 1'b0;
  logic [ADDR_W-1:0] dc_addr = '0;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_wnext;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_rvalid, dc_done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  always #5 clk = ~clk;

  sdram_cache_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .ic_req            (ic_req),
    .ic_addr           (ic_addr),
    .ic_rdata          (ic_rdata),
    .ic_rvalid         (ic_rvalid),
    .ic_done           (ic_done),
    .dc_req            (dc_req),
    .dc_we             (dc_we),
    .dc_addr           (dc_addr),
    .dc_wdata          (dc_wdata),
    .dc_wnext          (dc_wnext),
    .dc_rdata          (dc_rdata),
    .dc_rvalid         (dc_rvalid),
    .dc_done           (dc_done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic              is_dc;
    logic [DATA_W-1:0] data;
  } rd_t;

  typedef struct packed {
    int                due;
    logic [DATA_W-1:0] data;
    logic              stale;
  } ret_t;

  cmd_t exp_cmd[$];
  rd_t  exp_rd[$];
  ret_t pend[$];

  logic [DATA_W-1:0] wbuf [LW];
  int  wr_idx = 0;
  bit  wr_adv = 1'b0;
  int  lat = 2;
  int  wmode = 0;
  int  cyc = 0;
  int  outs_model = 0;
  int  acc_cnt = 0;
  int  ic_done_cnt = 0;
  int  dc_done_cnt = 0;
  bit  last_dc = 1'b1;   // arbitration model: reset pointer favours the I-cache

  // Slave memory contents as a function of word address
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[24:16], 7'h00};
  endfunction

  // Slave model and monitor: drive after negedge, sample 1 ns later
  initial begin : slave
    ret_t r;
    bit   ret_now;
    bit   acc;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    dc_wdata          = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (wr_adv) begin
        wr_idx++;
        wr_adv = 1'b0;
      end
      dc_wdata = wbuf[wr_idx % LW];
      case (wmode)
        0:       avm_waitrequest = 1'b0;
        1:       avm_waitrequest = ~avm_waitrequest;
        default: avm_waitrequest = 1'($urandom_range(0, 1));
      endcase
      ret_now = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = r.data;
        ret_now           = 1'b1;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = DATA_W'($urandom);
      end
      #1;
      if (ic_done) ic_done_cnt++;
      if (dc_done) dc_done_cnt++;
      if (rst_n) begin
        // read returns
        if (ret_now) begin
          if (r.stale) begin
            check_val("stale_rvalid", {30'd0, dc_rvalid, ic_rvalid}, 32'd0);
          end else if (exp_rd.size() == 0) begin
            check_val("rd_unexpected", 32'd1, 32'd0);
          end else begin
            rd_t e;
            e = exp_rd.pop_front();
            check_val("rd_owner", {30'd0, dc_rvalid, ic_rvalid}, e.is_dc ? 32'd2 : 32'd1);
            check_val("rd_data", e.is_dc ? dc_rdata : ic_rdata, e.data);
          end
        end else begin
          check_val("spurious_rvalid", {30'd0, dc_rvalid, ic_rvalid}, 32'd0);
        end
        // outstanding limit must throttle reads
        if (outs_model >= MO) check_val("read_throttled", avm_read, 1'b0);
        acc = avm_read && !avm_waitrequest;
        if (acc) begin
          check_val("outs_limit", outs_model < MO, 1'b1);
          if (exp_cmd.size() == 0) begin
            check_val("rd_cmd_unexpected", 32'd1, 32'd0);
          end else begin
            cmd_t c;
            c = exp_cmd.pop_front();
            check_val("rd_is_read", c.is_wr, 1'b0);
            check_val("rd_addr", avm_address, c.addr);
          end
          pend.push_back('{due: cyc + lat, data: mem_word(avm_address), stale: 1'b0});
          acc_cnt++;
        end
        outs_model = outs_model + (acc ? 1 : 0) - ((ret_now && !r.stale) ? 1 : 0);
        // write handshakes
        if (avm_write && !avm_waitrequest) begin
          check_val("wnext_on_accept", dc_wnext, 1'b1);
          if (exp_cmd.size() == 0) begin
            check_val("wr_cmd_unexpected", 32'd1, 32'd0);
          end else begin
            cmd_t c;
            c = exp_cmd.pop_front();
            check_val("wr_is_write", c.is_wr, 1'b1);
            check_val("wr_addr", avm_address, c.addr);
            check_val("wr_data", avm_writedata, c.wdata);
          end
          wr_adv = 1'b1;
        end else begin
          check_val("wnext_idle", dc_wnext, 1'b0);
        end
      end
    end
  end

  // Push the whole line's expected commands (and read returns) for one owner
  task automatic push_line(input bit is_dc, input bit we, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    base = addr & ~(ADDR_W'(LW - 1));
    for (int k = 0; k < LW; k++) begin
      a = base + ADDR_W'(k);
      if (we) begin
        wbuf[k] = DATA_W'($urandom);
        exp_cmd.push_back('{is_wr: 1'b1, addr: a, wdata: wbuf[k]});
      end else begin
        exp_cmd.push_back('{is_wr: 1'b0, addr: a, wdata: '0});
        exp_rd.push_back('{is_dc: is_dc, data: mem_word(a)});
      end
    end
    wr_idx   = 0;
    dc_wdata = wbuf[0];
    last_dc  = is_dc;
  endtask

  // Wait for the winner's done, release requests, check pulse counts
  task automatic wait_done(input bit is_dc, input int budget, input string tag);
    int s_ic, s_dc;
    s_ic = ic_done_cnt;
    s_dc = dc_done_cnt;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #2;
      if ((is_dc ? dc_done_cnt : ic_done_cnt) != (is_dc ? s_dc : s_ic)) break;
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_val({tag, "_done_once"}, is_dc ? dc_done_cnt - s_dc : ic_done_cnt - s_ic, 32'd1);
    check_val({tag, "_other_done"}, is_dc ? ic_done_cnt - s_ic : dc_done_cnt - s_dc, 32'd0);
    check_val({tag, "_cmd_left"}, exp_cmd.size(), 32'd0);
    check_val({tag, "_rd_left"}, exp_rd.size(), 32'd0);
  endtask

  task automatic do_txn(input bit is_dc, input bit we, input logic [ADDR_W-1:0] addr,
                        input string tag);
    @(negedge clk); #2;
    push_line(is_dc, we, addr);
    if (is_dc) begin
      dc_addr = addr;
      dc_we   = we;
      dc_req  = 1'b1;
    end else begin
      ic_addr = addr;
      ic_req  = 1'b1;
    end
    wait_done(is_dc, 400, tag);
  endtask

  task automatic do_tie(input string tag);
    bit win_dc;
`ifdef SDRAM_ARB_RR_EN
    win_dc = ~last_dc;
`else
    win_dc = 1'b1;
`endif
    @(negedge clk); #2;
    push_line(win_dc, 1'b0, win_dc ? 25'h0000840 : 25'h0000420);
    ic_addr = 25'h0000420;
    dc_addr = 25'h0000840;
    dc_we   = 1'b0;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    wait_done(win_dc, 400, tag);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int start_acc;
    for (int k = 0; k < LW; k++) wbuf[k] = '0;
    // Reset state
    #12;
    check_val("rst_avm_read", avm_read, 1'b0);
    check_val("rst_avm_write", avm_write, 1'b0);
    check_val("rst_avm_address", avm_address, 25'd0);
    check_val("rst_rvalid", {30'd0, dc_rvalid, ic_rvalid}, 32'd0);
    check_val("rst_done", {30'd0, dc_done, ic_done}, 32'd0);
    check_val("rst_wnext", dc_wnext, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // I-cache refill, no stalls, 2-cycle latency, unaligned request address
    lat = 2; wmode = 0;
    do_txn(1'b0, 1'b0, 25'h0000013, "t1_ic_read");

    // D-cache write-back at top of address space with alternating stalls
    wmode = 1;
    do_txn(1'b1, 1'b1, 25'h1FFFFF8, "t2_dc_write");
    wmode = 0;

    // Simultaneous requests, four rounds
    for (int i = 0; i < 4; i++) do_tie($sformatf("t3_tie%0d", i));

    // Long latency: outstanding throttling
    lat = 10;
    do_txn(1'b0, 1'b0, 25'h0000400, "t4_long_lat");

    // Unaligned base near top, random stalls, D-cache read
    lat = 3; wmode = 2;
    do_txn(1'b1, 1'b0, 25'h1FFFFFC, "t5_dc_read_top");
    wmode = 0;

    // Reset during a read with two reads outstanding
    lat = 10;
    @(negedge clk); #2;
    push_line(1'b0, 1'b0, 25'h0000200);
    ic_addr = 25'h0000200;
    ic_req  = 1'b1;
    start_acc = acc_cnt;
    for (int n = 0; n < 50 && (acc_cnt - start_acc) < 2; n++) begin
      @(negedge clk); #2;
    end
    check_val("t6_two_issued", acc_cnt - start_acc, 32'd2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_avm_read", avm_read, 1'b0);
    check_val("t6_rst_avm_address", avm_address, 25'd0);
    check_val("t6_rst_rvalid", {30'd0, dc_rvalid, ic_rvalid}, 32'd0);
    check_val("t6_rst_done", {30'd0, dc_done, ic_done}, 32'd0);
    exp_cmd.delete();
    exp_rd.delete();
    foreach (pend[i]) pend[i].stale = 1'b1;
    outs_model = 0;
    ic_req  = 1'b0;
    last_dc = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    #2;
    check_val("t6_stale_drained", pend.size(), 32'd0);
    lat = 2;
    do_txn(1'b0, 1'b0, 25'h0000305, "t6_after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
